apb_master: RTL
===============

Name: apb_master

Overview:
- Single APB initiator (bridge) between the RV32 core's data-bus request port and the APB peripheral fabric.
- Converts a one-cycle core request into an APB SETUP/ACCESS transfer and decodes the address into one of four PSELx lines.
- Muxes the selected slave's PRDATA/PREADY back to the core and returns a one-cycle completion pulse.
- Times out hung transfers and flags accesses to unmapped addresses.

Parameters:
- TIMEOUT, 16, max ACCESS cycles waiting for PREADY before forced error completion (≥2).
- BASE_ADDR, 32'h1000_0000, base of APB region; slave n occupies BASE_ADDR + n*0x1000 .. +0x0FFF.

Ports:
- PCLK  in  1  clock, all logic on rising edge
- PRESET  in  1  synchronous reset, active-high
- transfer  in  1  core request strobe; sampled only in IDLE
- write  in  1  1=write, 0=read
- addr  in  32  byte address
- wdata  in  32  write data
- strb_in  in  3  access size code (000 byte, 001 half, 010 word, 1xx unsigned loads), passed through
- rdata  out  32  read data returned to core
- ready  out  1  one-cycle completion pulse
- err  out  1  valid with ready; 1 = unmapped address or timeout
- PADDR  out  12  slave offset, addr[11:0] latched
- PWRITE  out  1  latched write
- PWDATA  out  32  latched wdata
- strb  out  3  latched strb_in
- PENABLE  out  1  APB enable
- PSEL0..PSEL3  out  1 each  slave selects (slave 0 = data RAM)
- PRDATA0..PRDATA3  in  32 each  slave read data
- PREADY0..PREADY3  in  1 each  slave ready

Behaviour:
- Reset (PRESET=1 at a PCLK edge): state=IDLE. All PSELx=0, PENABLE=0, PADDR=0, PWRITE=0, PWDATA=0, strb=0, rdata=0, ready=0, err=0, timeout counter=0. Reset mid-transfer aborts it with no ready pulse.
- Decode: sel = addr[13:12] when addr[31:14] == BASE_ADDR[31:14]; otherwise unmapped.
- IDLE:
  - If transfer=1 and mapped: latch PADDR/PWRITE/PWDATA/strb/sel, go to SETUP.
  - If transfer=1 and unmapped: go to ERR.
  - transfer=0: stay.
- SETUP (exactly 1 cycle): PSEL[sel]=1, PENABLE=0, go to ACCESS, clear counter.
- ACCESS: PSEL[sel]=1, PENABLE=1; PADDR/PWRITE/PWDATA/strb held stable.
  - On an edge with PREADY[sel]=1: rdata <= PRDATA[sel] for reads (rdata unchanged on writes), ready<=1, err<=0, go to IDLE.
  - Else counter++. When counter reaches TIMEOUT-1 without PREADY: rdata<=0, ready<=1, err<=1, go to IDLE.
- ERR (1 cycle): no PSEL asserted. rdata<=0, ready<=1, err<=1, go to IDLE.
- PSEL/PENABLE drop in the cycle ready is high.
- ready and err are registered and high exactly one cycle. err=0 whenever ready=0.
- PREADYx/PRDATAx of non-selected slaves, and all PREADYx outside ACCESS, are ignored. The data RAM holds PREADY high one cycle after ACCESS ends, so this rule is required.
- transfer asserted in any state other than IDLE is ignored; the core must hold off until ready.
- Back-to-back: transfer in the cycle ready=1 (state IDLE) is accepted.
- Latency against the data RAM (registered PREADY): transfer at cycle 0 → SETUP at 1 → ACCESS at 2–3 → ready at 4. Minimum with a zero-wait slave is 3 cycles.

Test Plan:
- Write then read RAM: write addr=0x1000_0010, wdata=0xCAFE_F00D → PSEL0 SETUP then ACCESS, PADDR=0x010, PWRITE=1, ready at cycle 4, err=0. Then read the same address → rdata=0xCAFE_F00D, ready at cycle 4.
- Decode: accesses to 0x1000_1004, 0x1000_2008, 0x1000_3FFC assert only PSEL1, PSEL2, PSEL3 respectively, with PADDR=0x004, 0x008, 0xFFC.
- Unmapped 0x2000_0000 read → no PSEL ever asserted, ready one cycle after ERR with err=1, rdata=0.
- Timeout: PREADY2 tied 0, read 0x1000_2000 → ACCESS held 16 cycles, then ready=1, err=1, rdata=0, PSEL2 deasserted.
- Wait states: PREADY1 asserted after 3 ACCESS cycles with PRDATA1=0x1234_5678 → PADDR/PENABLE stable throughout, rdata=0x1234_5678, err=0. Spurious PREADY1=1 during SETUP is ignored.
- Reset mid-ACCESS and back-to-back: PRESET during ACCESS → next cycle all outputs 0, no ready pulse. Two writes issued with transfer in the ready cycle → second SETUP immediately follows, both stored in RAM.

Source files
------------

// File: rtl/apb_master.sv
// -----------------------------------------------------------------------------
// apb_master
//
// APB initiator bridging the core data-bus request port onto four APB slaves.
// A one-cycle core request becomes an APB SETUP/ACCESS transfer; the address is
// decoded into one of four slave selects, the selected slave's PREADY/PRDATA
// are muxed back, and the core receives a registered one-cycle ready pulse.
// Unmapped addresses and transfers that wait too long for PREADY complete with
// err=1 and rdata=0.
//
// Ports:
//   PCLK, PRESET            clock (rising edge), synchronous active-high reset
//   transfer, write         request strobe (sampled in IDLE only), direction
//   addr, wdata, strb_in    request address, write data, access size code
//   rdata, ready, err       read data, completion pulse, error flag (with ready)
//   PADDR, PWRITE, PWDATA   latched slave offset, direction, write data
//   strb                    latched access size code
//   PENABLE, PSEL0..PSEL3   APB enable and per-slave selects
//   PRDATA0..3, PREADY0..3  per-slave read data and ready
// -----------------------------------------------------------------------------
module apb_master #(
  parameter int          TIMEOUT   = 16,
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        transfer,
  input  logic        write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  strb_in,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic [11:0] PADDR,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
  output logic [2:0]  strb,
  output logic        PENABLE,
  output logic        PSEL0,
  output logic        PSEL1,
  output logic        PSEL2,
  output logic        PSEL3,
  input  logic [31:0] PRDATA0,
  input  logic [31:0] PRDATA1,
  input  logic [31:0] PRDATA2,
  input  logic [31:0] PRDATA3,
  input  logic        PREADY0,
  input  logic        PREADY1,
  input  logic        PREADY2,
  input  logic        PREADY3
);

  localparam int               CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_ERR
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [1:0]       sel_q;

  logic             mapped;
  logic             load;
  logic             done;
  logic             done_err;
  logic             done_rd;
  logic             pready_sel;
  logic [31:0]      prdata_sel;
  logic             bus_act;

  // Only the top 18 address bits identify the APB region; bits 13:12 pick the
  // slave and bits 11:0 are the offset inside it.
  assign mapped = (addr[31:14] == BASE_ADDR[31:14]);

  // Return-path mux. Only the latched selection matters, so stray PREADY from
  // the other slaves can never complete a transfer.
  always_comb begin
    pready_sel = 1'b0;
    prdata_sel = '0;
    case (sel_q)
      2'd0: begin pready_sel = PREADY0; prdata_sel = PRDATA0; end
      2'd1: begin pready_sel = PREADY1; prdata_sel = PRDATA1; end
      2'd2: begin pready_sel = PREADY2; prdata_sel = PRDATA2; end
      default: begin pready_sel = PREADY3; prdata_sel = PRDATA3; end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load     = 1'b0;
    done     = 1'b0;
    done_err = 1'b0;
    done_rd  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (transfer) begin
          if (mapped) begin
            load    = 1'b1;
            state_d = ST_SETUP;
          end else begin
            state_d = ST_ERR;
          end
        end
      end
      ST_SETUP: begin
        cnt_d   = '0;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        // PREADY wins over the timeout on the final allowed ACCESS cycle.
        if (pready_sel) begin
          done    = 1'b1;
          done_rd = ~PWRITE;
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          done     = 1'b1;
          done_err = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_ERR: begin
        done     = 1'b1;
        done_err = 1'b1;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Selects are decoded from the registered state, so they fall in the same
  // cycle the registered ready pulse rises.
  assign bus_act = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign PENABLE = (state_q == ST_ACCESS);
  assign PSEL0   = bus_act && (sel_q == 2'd0);
  assign PSEL1   = bus_act && (sel_q == 2'd1);
  assign PSEL2   = bus_act && (sel_q == 2'd2);
  assign PSEL3   = bus_act && (sel_q == 2'd3);

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      PADDR   <= '0;
      PWRITE  <= 1'b0;
      PWDATA  <= '0;
      strb    <= '0;
      rdata   <= '0;
      ready   <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready   <= done;
      err     <= done_err;
      if (load) begin
        sel_q  <= addr[13:12];
        PADDR  <= addr[11:0];
        PWRITE <= write;
        PWDATA <= wdata;
        strb   <= strb_in;
      end
      // Writes leave rdata untouched; errors always return zero.
      if (done_err) begin
        rdata <= '0;
      end else if (done_rd) begin
        rdata <= prdata_sel;
      end
    end
  end

endmodule
